// File: rtl/fixed_sqrt_if.sv
// Ready/valid handshake bundle for the fixed-point square-root unit.
interface fixed_sqrt_if #(
  parameter int unsigned NBITS = 8
);
  logic [NBITS-1:0] A;
  logic             iValid;
  logic             iReady;
  logic [NBITS-1:0] result;
  logic             oValid;
  logic             oReady;

  modport master (output A, iValid, oReady, input iReady, result, oValid);
  modport slave  (input A, iValid, oReady, output iReady, result, oValid);
endinterface

// File: rtl/fixed_sqrt.sv
// Sequential restoring square root: result = min(floor(sqrt(A) * 2^F), 2^NBITS-1),
// one root digit per clock, ready/valid on both sides.
module fixed_sqrt #(
  parameter int unsigned NBITS          = 8,
  parameter int unsigned HALF_PRECISION = 5
) (
  input logic         clock,
  input logic         reset,
  fixed_sqrt_if.slave bus
);
  localparam int unsigned W    = NBITS + 2 * HALF_PRECISION;
  localparam int unsigned K    = (W + 1) / 2;
  localparam int unsigned RADW = 2 * K;
  localparam int unsigned RW   = K + 2;
  localparam int unsigned CW   = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_nxt;
  logic [RADW-1:0] rad;
  logic [K-1:0]    root, root_nxt;
  logic [RW-1:0]   rem, rem_nxt;
  logic [CW-1:0]   cnt;
  logic            iready_nxt, ovalid_nxt;
  logic [RW+1:0]   rem_sh_c;
  logic [RW+1:0]   trial_c;
  logic            ge_c;
  logic [NBITS-1:0] sat_c;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.iValid) state_nxt = BUSY;
      BUSY:    if (cnt == '0)  state_nxt = DONE;
      DONE:    if (bus.oReady) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state, then registered
  always_comb begin
    iready_nxt = 1'b0;
    ovalid_nxt = 1'b0;
    if (state_nxt == IDLE) iready_nxt = 1'b1;
    if (state_nxt == DONE) ovalid_nxt = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bus.iReady <= 1'b1;
      bus.oValid <= 1'b0;
    end else begin
      bus.iReady <= iready_nxt;
      bus.oValid <= ovalid_nxt;
    end
  end

  // One restoring iteration: bring down two radicand bits, try (root<<2)|1
  always_comb begin
    rem_sh_c = {rem, rad[RADW-1 -: 2]};
    trial_c  = (RW + 2)'({root, 2'b01});
    ge_c     = (rem_sh_c >= trial_c);
    rem_nxt  = ge_c ? RW'(rem_sh_c - trial_c) : RW'(rem_sh_c);
    root_nxt = (root << 1) | K'(ge_c);
  end

  // Saturate the root only when it can be wider than the result
  generate
    if (K > NBITS) begin : g_sat
      assign sat_c = (|root_nxt[K-1:NBITS]) ? '1 : root_nxt[NBITS-1:0];
    end else begin : g_nosat
      assign sat_c = NBITS'(root_nxt);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (!reset) begin
      rad        <= '0;
      root       <= '0;
      rem        <= '0;
      cnt        <= '0;
      bus.result <= '0;
    end else begin
      case (state)
        IDLE: if (bus.iValid) begin
          rad  <= RADW'(bus.A) << (2 * HALF_PRECISION);
          root <= '0;
          rem  <= '0;
          cnt  <= CW'(K - 1);
        end
        BUSY: begin
          rad  <= rad << 2;
          root <= root_nxt;
          rem  <= rem_nxt;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) bus.result <= sat_c;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fixed_sqrt.sv
// Directed and exhaustive checks for fixed_sqrt with default parameters (NBITS=8, F=5).
module tb_fixed_sqrt;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  fixed_sqrt_if #(.NBITS(8)) bus ();

  fixed_sqrt #(.NBITS(8), .HALF_PRECISION(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] a;
    int         exp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Independent reference: largest r with r*r <= A*1024, clipped to 255
  function automatic int ref_sqrt(input int a);
    int r = 0;
    while ((r + 1) * (r + 1) <= a * 1024) r++;
    return (r > 255) ? 255 : r;
  endfunction

  // Issue one operation with oReady high and check latency and value
  task automatic run_op(input logic [7:0] a, input int exp, input string name);
    int lat = 0;
    @(negedge clock);
    bus.A = a; bus.iValid = 1'b1; bus.oReady = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.iValid = 1'b0;
    while (lat < 30) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (bus.oValid) break;
    end
    check({name, "_latency"}, lat, 9);
    check({name, "_result"}, int'(bus.result), exp);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!(bus.iReady && !bus.oValid) && n < 40) begin
      @(negedge clock);
      n++;
    end
    check({name, "_drain_idle"}, int'(bus.iReady && !bus.oValid), 1);
  endtask

  initial begin
    int lat;
    int rises[$];
    logic prev;

    vecs[0] = '{8'd6,   78};
    vecs[1] = '{8'd0,   0};
    vecs[2] = '{8'd1,   32};
    vecs[3] = '{8'd2,   45};
    vecs[4] = '{8'd4,   64};
    vecs[5] = '{8'd63,  253};
    vecs[6] = '{8'd64,  255};
    vecs[7] = '{8'd255, 255};

    bus.A = '0; bus.iValid = 1'b0; bus.oReady = 1'b0;

    // Reset and idle behaviour
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_iready", int'(bus.iReady), 1);
    check("rst_ovalid", int'(bus.oValid), 0);
    check("rst_result", int'(bus.result), 0);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    check("idle_iready", int'(bus.iReady), 1);
    check("idle_ovalid", int'(bus.oValid), 0);

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].exp, $sformatf("vec%0d_a%0d", i, vecs[i].a));

    // Backpressure: result must hold while oReady is low
    @(negedge clock);
    bus.A = 8'd6; bus.iValid = 1'b1; bus.oReady = 1'b0;
    @(posedge clock);
    @(negedge clock);
    bus.iValid = 1'b0;
    lat = 0;
    while (!bus.oValid && lat < 30) begin
      @(negedge clock);
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      check("bp_ovalid", int'(bus.oValid), 1);
      check("bp_result", int'(bus.result), 78);
      check("bp_iready", int'(bus.iReady), 0);
      @(negedge clock);
    end
    bus.oReady = 1'b1;
    @(negedge clock);
    check("bp_release_ovalid", int'(bus.oValid), 0);
    check("bp_release_iready", int'(bus.iReady), 1);

    // Input isolation: A and iValid wiggle during BUSY
    bus.A = 8'd6; bus.iValid = 1'b1; bus.oReady = 1'b1;
    @(posedge clock);
    lat = 0;
    @(negedge clock);
    bus.A = 8'd200;
    while (!bus.oValid && lat < 30) begin
      bus.iValid = ~bus.iValid;
      @(negedge clock);
      lat++;
    end
    bus.iValid = 1'b0;
    check("iso_result", int'(bus.result), 78);
    wait_idle("iso");

    // Reset in the middle of an operation discards it
    bus.A = 8'd6; bus.iValid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.iValid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check("midrst_iready", int'(bus.iReady), 1);
    check("midrst_ovalid", int'(bus.oValid), 0);
    check("midrst_result", int'(bus.result), 0);
    repeat (12) begin
      @(negedge clock);
      check("midrst_no_ovalid", int'(bus.oValid), 0);
    end
    run_op(8'd1, 32, "midrst_after");

    // Back-to-back with both handshakes held high
    @(negedge clock);
    bus.A = 8'd9; bus.iValid = 1'b1; bus.oReady = 1'b1;
    prev = 1'b0;
    for (int c = 0; c < 60 && rises.size() < 3; c++) begin
      @(negedge clock);
      if (bus.oValid && !prev) begin
        rises.push_back(c);
        check("b2b_result", int'(bus.result), 96);
      end
      prev = bus.oValid;
    end
    bus.iValid = 1'b0;
    check("b2b_count", rises.size(), 3);
    if (rises.size() == 3) begin
      check("b2b_period1", rises[1] - rises[0], 11);
      check("b2b_period2", rises[2] - rises[1], 11);
    end
    wait_idle("b2b");

    // Exhaustive sweep against the reference model
    for (int a = 0; a < 256; a++) run_op(8'(a), ref_sqrt(a), $sformatf("sweep_a%0d", a));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
